// File: rtl/mio_pkg.sv
// Shared definitions for the CPU data-side bridge: address map codes,
// peripheral selects and the bridge FSM state type.
package mio_pkg;

    localparam logic [3:0] REG_RAM    = 4'h0;
    localparam logic [3:0] REG_GPIO   = 4'hE;
    localparam logic [3:0] REG_PERIPH = 4'hF;

    localparam logic [1:0] OFF_SW  = 2'd0;
    localparam logic [1:0] OFF_CNT = 2'd1;

    localparam logic [31:0] UNMAPPED_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAM_WAIT,
        ST_RESP
    } mio_state_e;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_GPIO,
        SEL_SW,
        SEL_CNT
    } periph_sel_e;

endpackage

// File: rtl/mio_periph_regs.sv
// On-chip peripheral registers behind the bridge: GPIO output, synchronised
// switch inputs and a free-running 32-bit cycle counter.
module mio_periph_regs
    import mio_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_i,
    input  periph_sel_e sel_i,
    input  logic [31:0] wdata_i,
    input  logic [15:0] sw_in_i,
    output logic [31:0] rdata_o,
    output logic [31:0] gpio_o
);

    logic [31:0] gpio_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    logic [15:0] sw_meta_q;
    logic [15:0] sw_sync_q;

    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (wr_i && sel_i == SEL_CNT) begin
            cnt_d = wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_q    <= '0;
            cnt_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            if (wr_i && sel_i == SEL_GPIO) begin
                gpio_q <= wdata_i;
            end
            cnt_q     <= cnt_d;
            sw_meta_q <= sw_in_i;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Counter reads report the count as it stands after the acceptance edge.
    always_comb begin
        rdata_o = '0;
        case (sel_i)
            SEL_GPIO: rdata_o = gpio_q;
            SEL_SW:   rdata_o = {16'h0000, sw_sync_q};
            SEL_CNT:  rdata_o = cnt_q + 32'd1;
            default:  rdata_o = '0;
        endcase
    end

    assign gpio_o = gpio_q;

endmodule

// File: rtl/mio_data_bridge.sv
// MEM-stage data bridge: decodes CPU data requests onto the data RAM or the
// peripheral registers and returns read data with a one-cycle ready pulse.
module mio_data_bridge
    import mio_pkg::*;
#(
    parameter int          RAM_AW        = 10,
    parameter int          RAM_LATENCY   = 1,
    parameter logic [31:0] UNMAPPED_DATA = UNMAPPED_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_mio,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              mio_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       sw_in,
    output logic [31:0]       gpio_out,
    output logic              bus_err
);

    localparam logic [1:0] WAIT_INIT = 2'(RAM_LATENCY);

    mio_state_e        state_q;
    logic [1:0]        wait_q;
    logic [31:0]       rdata_q;
    logic              mio_ready_q;
    logic              ram_en_q;
    logic              ram_we_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic [31:0]       ram_wdata_q;
    logic              bus_err_q;

    logic [3:0]  region;
    logic [1:0]  offset;
    periph_sel_e sel;
    logic        is_ram;
    logic        unmapped;
    logic        accept;
    logic        periph_wr;
    logic [31:0] periph_rdata;
    logic        unused_addr_bits;

    assign region           = cpu_addr[31:28];
    assign offset           = cpu_addr[3:2];
    assign unused_addr_bits = ^{cpu_addr[27:RAM_AW+2], cpu_addr[1:0]};

    always_comb begin
        sel = SEL_NONE;
        if (region == REG_GPIO) begin
            sel = SEL_GPIO;
        end else if (region == REG_PERIPH && offset == OFF_SW) begin
            sel = SEL_SW;
        end else if (region == REG_PERIPH && offset == OFF_CNT) begin
            sel = SEL_CNT;
        end
    end

    assign is_ram   = (region == REG_RAM);
    assign unmapped = !is_ram && (sel == SEL_NONE);

    // The CPU still holds cpu_mio during the ready cycle, so that cycle must not re-accept.
    assign accept    = (state_q == ST_IDLE) && cpu_mio && !mio_ready_q;
    assign periph_wr = accept && cpu_we;

    mio_periph_regs u_periph (
        .clk     (clk),
        .rst     (rst),
        .wr_i    (periph_wr),
        .sel_i   (sel),
        .wdata_i (cpu_wdata),
        .sw_in_i (sw_in),
        .rdata_o (periph_rdata),
        .gpio_o  (gpio_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            rdata_q     <= '0;
            mio_ready_q <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            mio_ready_q <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_ram) begin
                            ram_en_q   <= 1'b1;
                            ram_addr_q <= cpu_addr[RAM_AW+1:2];
                            if (cpu_we) begin
                                ram_we_q    <= 1'b1;
                                ram_wdata_q <= cpu_wdata;
                                state_q     <= ST_RESP;
                            end else begin
                                wait_q  <= WAIT_INIT;
                                state_q <= ST_RAM_WAIT;
                            end
                        end else begin
                            if (unmapped) begin
                                bus_err_q <= 1'b1;
                            end
                            if (!cpu_we) begin
                                rdata_q <= unmapped ? UNMAPPED_DATA : periph_rdata;
                            end
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_RAM_WAIT: begin
                    wait_q <= wait_q - 2'd1;
                    if (wait_q == 2'd1) begin
                        rdata_q <= ram_rdata;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    mio_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cpu_rdata = rdata_q;
    assign mio_ready = mio_ready_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mio_data_bridge.sv
// Directed bench for mio_data_bridge: one instance at RAM_LATENCY=1 and one at
// RAM_LATENCY=3, each with its own behavioural RAM.
module tb_mio_data_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [15:0] sw_in;

    logic        cpu_mio, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        mio_ready, ram_en, ram_we, bus_err;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata, gpio_out;

    logic        cpu_mio3, cpu_we3;
    logic [31:0] cpu_addr3, cpu_wdata3, cpu_rdata3;
    logic        mio_ready3, ram_en3, ram_we3, bus_err3;
    logic [9:0]  ram_addr3;
    logic [31:0] ram_wdata3, ram_rdata3, gpio_out3;

    mio_data_bridge u_dut (
        .clk(clk), .rst(rst), .cpu_mio(cpu_mio), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .mio_ready(mio_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .sw_in(sw_in), .gpio_out(gpio_out), .bus_err(bus_err)
    );

    mio_data_bridge #(.RAM_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .cpu_mio(cpu_mio3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3),
        .cpu_wdata(cpu_wdata3), .cpu_rdata(cpu_rdata3), .mio_ready(mio_ready3),
        .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
        .ram_rdata(ram_rdata3), .sw_in(sw_in), .gpio_out(gpio_out3), .bus_err(bus_err3)
    );

    // Latency 1: read data valid during the ram_en cycle from the registered address.
    logic [31:0] mem1 [1024];
    always @(posedge clk) if (ram_en && ram_we) mem1[ram_addr] <= ram_wdata;
    assign ram_rdata = mem1[ram_addr];

    // Latency 3: two extra pipeline stages behind the array read.
    logic [31:0] mem3 [1024];
    logic [31:0] pipe1, pipe2;
    always @(posedge clk) begin
        if (ram_en3 && ram_we3) mem3[ram_addr3] <= ram_wdata3;
        pipe1 <= mem3[ram_addr3];
        pipe2 <= pipe1;
    end
    assign ram_rdata3 = pipe2;

    int checks = 0;
    int errors = 0;

    int          lat, en_cycles, rdy_seen;
    logic        seen_we;
    logic [9:0]  seen_addr;
    logic [31:0] seen_wdata, rd, gpio_at1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on u_dut at a negedge and hold it until mio_ready.
    task automatic req1(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        cpu_mio = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        lat = 0; en_cycles = 0; seen_we = 1'b0; seen_addr = '0; seen_wdata = '0; gpio_at1 = '0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) gpio_at1 = gpio_out;
            if (ram_en) begin
                en_cycles++;
                seen_we = ram_we; seen_addr = ram_addr; seen_wdata = ram_wdata;
            end
        end while (!mio_ready && lat < 20);
        rd = cpu_rdata;
        cpu_mio = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        @(negedge clk);
        check("ready_pulse_width", 32'(mio_ready), 32'd0);
    endtask

    task automatic req3(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        cpu_mio3 = 1'b1; cpu_we3 = we; cpu_addr3 = addr; cpu_wdata3 = wd;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mio_ready3 && lat < 20);
        rd = cpu_rdata3;
        cpu_mio3 = 1'b0; cpu_we3 = 1'b0; cpu_addr3 = '0; cpu_wdata3 = '0;
        @(negedge clk);
        check("ready3_pulse_width", 32'(mio_ready3), 32'd0);
    endtask

    initial begin
        rst = 1'b0; sw_in = '0;
        cpu_mio = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_mio3 = 1'b0; cpu_we3 = 1'b0; cpu_addr3 = '0; cpu_wdata3 = '0;
        repeat (2) @(negedge clk);

        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_mio_ready", 32'(mio_ready), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_gpio_out", gpio_out, 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        req1(1'b1, 32'h0000_0010, 32'h1234_5678);
        check("ramwr_latency", 32'(lat), 32'd2);
        check("ramwr_en_cycles", 32'(en_cycles), 32'd1);
        check("ramwr_we", 32'(seen_we), 32'd1);
        check("ramwr_addr", 32'(seen_addr), 32'd4);
        check("ramwr_wdata", seen_wdata, 32'h1234_5678);

        req1(1'b0, 32'h0000_0010, 32'h0);
        check("ramrd_latency", 32'(lat), 32'd3);
        check("ramrd_we", 32'(seen_we), 32'd0);
        check("ramrd_addr", 32'(seen_addr), 32'd4);
        check("ramrd_data", rd, 32'h1234_5678);

        req1(1'b1, 32'h0000_0FFC, 32'hA5A5_0FFC);
        check("ramwr_top_addr", 32'(seen_addr), 32'd1023);
        req1(1'b0, 32'h0000_0FFC, 32'h0);
        check("ramrd_top_data", rd, 32'hA5A5_0FFC);

        req1(1'b1, 32'hE000_0000, 32'h0000_00A5);
        check("gpiowr_latency", 32'(lat), 32'd2);
        check("gpiowr_at_accept", gpio_at1, 32'h0000_00A5);
        check("gpiowr_no_ram", 32'(en_cycles), 32'd0);
        req1(1'b0, 32'hE000_0000, 32'h0);
        check("gpiord_latency", 32'(lat), 32'd2);
        check("gpiord_data", rd, 32'h0000_00A5);

        sw_in = 16'hBEEF;
        repeat (3) @(negedge clk);
        req1(1'b0, 32'hF000_0000, 32'h0);
        check("sw_latency", 32'(lat), 32'd2);
        check("sw_data", rd, 32'h0000_BEEF);
        req1(1'b1, 32'hF000_0000, 32'hFFFF_FFFF);
        check("swwr_latency", 32'(lat), 32'd2);
        check("swwr_gpio_kept", gpio_out, 32'h0000_00A5);

        req1(1'b1, 32'hF000_0004, 32'hFFFF_FFFE);
        check("cntwr_latency", 32'(lat), 32'd2);
        req1(1'b0, 32'hF000_0004, 32'h0);
        check("cnt_wrapped", rd, 32'h0000_0001);
        req1(1'b0, 32'hF000_0004, 32'h0);
        check("cnt_second", rd, 32'h0000_0004);

        check("bus_err_clear", 32'(bus_err), 32'd0);
        req1(1'b0, 32'h5000_0000, 32'h0);
        check("unmapped_latency", 32'(lat), 32'd2);
        check("unmapped_data", rd, 32'hDEAD_BEEF);
        check("unmapped_bus_err", 32'(bus_err), 32'd1);
        req1(1'b1, 32'hF000_0008, 32'h0000_0001);
        check("unmapped_wr_latency", 32'(lat), 32'd2);
        check("unmapped_wr_dropped", gpio_out, 32'h0000_00A5);
        req1(1'b0, 32'hE000_0000, 32'h0);
        check("bus_err_sticky", 32'(bus_err), 32'd1);
        check("gpio_after_err", rd, 32'h0000_00A5);

        req3(1'b1, 32'h0000_0020, 32'hCAFE_0001);
        check("lat3_wr_latency", 32'(lat), 32'd2);
        req3(1'b0, 32'h0000_0020, 32'h0);
        check("lat3_rd_latency", 32'(lat), 32'd5);
        check("lat3_rd_data", rd, 32'hCAFE_0001);

        cpu_mio3 = 1'b1; cpu_we3 = 1'b0; cpu_addr3 = 32'h0000_0020;
        @(negedge clk);
        check("midrst_ram_en_before", 32'(ram_en3), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_ram_en", 32'(ram_en3), 32'd0);
        check("midrst_cpu_rdata", cpu_rdata3, 32'h0);
        check("midrst_mio_ready", 32'(mio_ready3), 32'd0);
        check("midrst_bus_err", 32'(bus_err), 32'd0);
        check("midrst_gpio", gpio_out, 32'h0);
        check("midrst_bus_err3", 32'(bus_err3) | gpio_out3, 32'h0);
        cpu_mio3 = 1'b0; cpu_addr3 = '0;
        rdy_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (mio_ready3) rdy_seen++;
        end
        check("midrst_no_ready", 32'(rdy_seen), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        req3(1'b0, 32'h0000_0020, 32'h0);
        check("postrst_latency", 32'(lat), 32'd5);
        check("postrst_data", rd, 32'hCAFE_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
